// File: rtl/led_bar_mon_pkg.sv
// Shared types and helpers for the LED bar sequence monitor.
package led_bar_mon_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_UNLOCKED,
        ST_SYNC,
        ST_FILL,
        ST_FULL,
        ST_DRAIN,
        ST_EMPTY
    } bar_state_e;

    function automatic int LVL_W(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bar_shape_decode.sv
// Combinational decode of an LED bar pattern: lit count and whether the lit
// LEDs form one contiguous run anchored at the end selected by i_mode.
module bar_shape_decode
    import led_bar_mon_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]        i_bar,
    input  logic                    i_mode,
    output logic                    o_valid,
    output logic [LVL_W(WIDTH)-1:0] o_level
);

    localparam int LW = LVL_W(WIDTH);

    logic [LW-1:0]    w_cnt;
    logic [WIDTH-1:0] w_pat;

    always_comb begin
        w_cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_cnt = w_cnt + LW'(i_bar[i]);
        end
        // Rebuild the ideal pattern for this count and compare against the input
        w_pat = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i_mode) w_pat[i] = (i + 32'(w_cnt) >= WIDTH);
            else        w_pat[i] = (i < 32'(w_cnt));
        end
        o_valid = (w_pat == i_bar);
        o_level = w_cnt;
    end

endmodule

// File: rtl/led_bar_monitor.sv
// Tracks the fill / full-hold / drain / empty-hold sequence of an LED bar.
// Define BAR_MON_ERRCAP_EN to add err_exp/err_got first-violation capture.
module led_bar_monitor
    import led_bar_mon_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_en,
    input  logic                    mode,
    input  logic [WIDTH-1:0]        bar_in,
    input  logic                    clr_err,
    output logic [LVL_W(WIDTH)-1:0] level,
    output logic                    phase,
    output logic                    locked,
    output logic                    err,
    output logic [CNT_W-1:0]        err_cnt,
    output logic                    cycle_done
`ifdef BAR_MON_ERRCAP_EN
    ,
    output logic [WIDTH-1:0]        err_exp,
    output logic [WIDTH-1:0]        err_got
`endif
);

    localparam int LW = LVL_W(WIDTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(WIDTH);

    bar_state_e  r_state, w_state_nxt, w_state_eff;
    logic [LW-1:0] r_level;
    logic          r_mode;
    logic          r_err, r_cycle_done;
    logic [CNT_W-1:0] r_err_cnt;

    logic          w_valid;
    logic [LW-1:0] w_lvl;
    logic [LW-1:0] w_exp_lvl;
    logic          w_err, w_done;

    bar_shape_decode #(.WIDTH(WIDTH)) u_decode (
        .i_bar   (bar_in),
        .i_mode  (mode),
        .o_valid (w_valid),
        .o_level (w_lvl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_UNLOCKED;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        unique case (r_state)
            ST_FILL:  w_exp_lvl = r_level + LW'(1);
            ST_FULL:  w_exp_lvl = FULL_LVL;
            ST_DRAIN: w_exp_lvl = r_level - LW'(1);
            default:  w_exp_lvl = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_done      = 1'b0;
        // A mode change restarts acquisition on the same sample, without an error
        w_state_eff = r_state;
        if (r_state != ST_UNLOCKED && mode != r_mode) w_state_eff = ST_UNLOCKED;
        if (sample_en) begin
            unique case (w_state_eff)
                ST_UNLOCKED: w_state_nxt = w_valid ? ST_SYNC : ST_UNLOCKED;
                ST_SYNC: begin
                    if (!w_valid)
                        w_state_nxt = ST_UNLOCKED;
                    else if (w_lvl == r_level + LW'(1))
                        w_state_nxt = (w_lvl == FULL_LVL) ? ST_FULL : ST_FILL;
                    else if (r_level != '0 && w_lvl == r_level - LW'(1))
                        w_state_nxt = (w_lvl == '0) ? ST_EMPTY : ST_DRAIN;
                    else if (w_lvl == r_level && r_level == FULL_LVL)
                        w_state_nxt = ST_DRAIN;
                    else if (w_lvl == r_level && r_level == '0)
                        w_state_nxt = ST_FILL;
                    else
                        w_state_nxt = ST_SYNC;
                end
                default: begin
                    if (w_valid && w_lvl == w_exp_lvl) begin
                        unique case (w_state_eff)
                            ST_FILL:  w_state_nxt = (w_lvl == FULL_LVL) ? ST_FULL : ST_FILL;
                            ST_FULL:  w_state_nxt = ST_DRAIN;
                            ST_DRAIN: w_state_nxt = (w_lvl == '0) ? ST_EMPTY : ST_DRAIN;
                            default: begin
                                w_state_nxt = ST_FILL;
                                w_done      = 1'b1;
                            end
                        endcase
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = w_valid ? ST_SYNC : ST_UNLOCKED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level      <= '0;
            r_mode       <= 1'b0;
            r_err        <= 1'b0;
            r_cycle_done <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            if (sample_en && w_valid) begin
                r_level <= w_lvl;
                r_mode  <= mode;
            end
            r_err        <= w_err;
            r_cycle_done <= w_done;
            // A violation in the clear cycle wins over the clear
            if (w_err) begin
                if (clr_err)              r_err_cnt <= CNT_W'(1);
                else if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
            end else if (clr_err) begin
                r_err_cnt <= '0;
            end
        end
    end

`ifdef BAR_MON_ERRCAP_EN
    logic             r_cap_done;
    logic [WIDTH-1:0] r_err_exp, r_err_got;

    function automatic logic [WIDTH-1:0] f_pattern(input logic [LW-1:0] lvl, input logic m);
        logic [WIDTH-1:0] pat;
        pat = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (m) pat[i] = (i + 32'(lvl) >= WIDTH);
            else   pat[i] = (i < 32'(lvl));
        end
        return pat;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_done <= 1'b0;
            r_err_exp  <= '0;
            r_err_got  <= '0;
        end else if (w_err && (!r_cap_done || clr_err)) begin
            r_cap_done <= 1'b1;
            r_err_exp  <= f_pattern(w_exp_lvl, mode);
            r_err_got  <= bar_in;
        end else if (clr_err) begin
            r_cap_done <= 1'b0;
            r_err_exp  <= '0;
            r_err_got  <= '0;
        end
    end

    assign err_exp = r_err_exp;
    assign err_got = r_err_got;
`endif

    always_comb begin
        level      = r_level;
        phase      = (r_state inside {ST_FULL, ST_DRAIN});
        locked     = (r_state inside {ST_FILL, ST_FULL, ST_DRAIN, ST_EMPTY});
        err        = r_err;
        err_cnt    = r_err_cnt;
        cycle_done = r_cycle_done;
    end

endmodule

// File: tb/tb_led_bar_monitor.sv
// Scoreboard bench for led_bar_monitor: a behavioural model queues the expected
// outputs for every driven sample; they are checked one cycle later.
module tb_led_bar_monitor;

    localparam int S_UNL = 0, S_SYNC = 1, S_FILL = 2, S_FULL = 3, S_DRAIN = 4, S_EMPTY = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_en = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] bar_in = 8'h00;
    logic       clr_err = 1'b0;
    logic [3:0] level;
    logic       phase, locked, err, cycle_done;
    logic [7:0] err_cnt;
`ifdef BAR_MON_ERRCAP_EN
    logic [7:0] err_exp, err_got;
`endif

    led_bar_monitor #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .mode       (mode),
        .bar_in     (bar_in),
        .clr_err    (clr_err),
        .level      (level),
        .phase      (phase),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt),
        .cycle_done (cycle_done)
`ifdef BAR_MON_ERRCAP_EN
        ,
        .err_exp    (err_exp),
        .err_got    (err_got)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int level, phase, locked, err, cnt, done, cexp, cgot;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_state, m_prev, m_mode, m_cnt, m_cap, m_exp, m_got;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_UNL; m_prev = 0; m_mode = 0; m_cnt = 0;
        m_cap = 0; m_exp = 0; m_got = 0;
    endtask

    task automatic model(input logic [7:0] b, input logic md, input logic en, input logic clr,
                         output exp_t e);
        logic [7:0] ones;
        logic [7:0] pat;
        int  L, st, expl;
        bit  ok, e_err, e_done;
        ones = 8'hFF;
        e_err = 0; e_done = 0;
        L  = $countones(b);
        ok = md ? (b == ~(ones >> L)) : (b == ~(ones << L));
        if (en) begin
            st = m_state;
            if (st != S_UNL && int'(md) != m_mode) st = S_UNL;
            case (st)
                S_UNL:  m_state = ok ? S_SYNC : S_UNL;
                S_SYNC: begin
                    if (!ok)                          m_state = S_UNL;
                    else if (L == m_prev + 1)         m_state = (L == 8) ? S_FULL : S_FILL;
                    else if (L == m_prev - 1)         m_state = (L == 0) ? S_EMPTY : S_DRAIN;
                    else if (L == m_prev && L == 8)   m_state = S_DRAIN;
                    else if (L == m_prev && L == 0)   m_state = S_FILL;
                    else                              m_state = S_SYNC;
                end
                default: begin
                    expl = (st == S_FILL) ? m_prev + 1 : (st == S_FULL) ? 8 :
                           (st == S_DRAIN) ? m_prev - 1 : 0;
                    if (ok && L == expl) begin
                        if (st == S_FILL)       m_state = (L == 8) ? S_FULL : S_FILL;
                        else if (st == S_FULL)  m_state = S_DRAIN;
                        else if (st == S_DRAIN) m_state = (L == 0) ? S_EMPTY : S_DRAIN;
                        else begin m_state = S_FILL; e_done = 1; end
                    end else begin
                        e_err   = 1;
                        m_state = ok ? S_SYNC : S_UNL;
                        if (!m_cap || clr) begin
                            pat   = md ? ~(ones >> expl) : ~(ones << expl);
                            m_exp = int'(pat);
                            m_got = int'(b);
                            m_cap = 1;
                        end
                    end
                end
            endcase
            if (ok) begin m_prev = L; m_mode = int'(md); end
        end
        if (e_err) m_cnt = clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
        else if (clr) begin
            m_cnt = 0; m_cap = 0; m_exp = 0; m_got = 0;
        end
        e.level  = m_prev;
        e.phase  = (m_state == S_FULL || m_state == S_DRAIN) ? 1 : 0;
        e.locked = (m_state >= S_FILL) ? 1 : 0;
        e.err    = e_err ? 1 : 0;
        e.cnt    = m_cnt;
        e.done   = e_done ? 1 : 0;
        e.cexp   = m_exp;
        e.cgot   = m_got;
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq({tag, "_level"},  32'(level),      e.level);
            check_eq({tag, "_phase"},  32'(phase),      e.phase);
            check_eq({tag, "_locked"}, 32'(locked),     e.locked);
            check_eq({tag, "_err"},    32'(err),        e.err);
            check_eq({tag, "_errcnt"}, 32'(err_cnt),    e.cnt);
            check_eq({tag, "_done"},   32'(cycle_done), e.done);
`ifdef BAR_MON_ERRCAP_EN
            check_eq({tag, "_cexp"},   32'(err_exp),    e.cexp);
            check_eq({tag, "_cgot"},   32'(err_got),    e.cgot);
`endif
        end
    endtask

    task automatic step(input string tag, input logic [7:0] b, input logic md = 1'b0,
                        input logic en = 1'b1, input logic clr = 1'b0);
        exp_t e;
        @(negedge clk);
        bar_in = b; mode = md; sample_en = en; clr_err = clr;
        model(b, md, en, clr, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_level"},  32'(level),      0);
        check_eq({tag, "_phase"},  32'(phase),      0);
        check_eq({tag, "_locked"}, 32'(locked),     0);
        check_eq({tag, "_err"},    32'(err),        0);
        check_eq({tag, "_errcnt"}, 32'(err_cnt),    0);
        check_eq({tag, "_done"},   32'(cycle_done), 0);
`ifdef BAR_MON_ERRCAP_EN
        check_eq({tag, "_cexp"},   32'(err_exp),    0);
        check_eq({tag, "_cgot"},   32'(err_got),    0);
`endif
    endtask

    logic [7:0] seq0 [20] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFF,
                              8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01};
    logic [7:0] seq1 [20] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF,
                              8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h80};
    logic [7:0] t3 [8] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h05, 8'h07, 8'h0F, 8'h1F};
    logic [7:0] t4 [7] = '{8'h00, 8'h01, 8'h03, 8'h0F, 8'hFF, 8'hFF, 8'hFF};

    initial begin
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        foreach (seq0[i]) step("seq_m0", seq0[i], 1'b0);

        foreach (seq1[i]) step("seq_m1", seq1[i], 1'b1);
        step("mchg_a", 8'h00, 1'b0);
        step("mchg_b", 8'h00, 1'b0);
        step("mchg_c", 8'h01, 1'b0);
        step("m0_80",  8'h80, 1'b0);

        foreach (t3[i]) step("relock", t3[i]);

        foreach (t4[i]) step("skip_hold", t4[i]);
        step("clr_a", 8'h00);
        step("clr_b", 8'h00);
        step("clr_c", 8'h01);
        step("clr_err", 8'h05, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 300; k++) begin
            step("sat_a", 8'h00);
            step("sat_b", 8'h00);
            step("sat_e", 8'h05);
        end
        step("clr_only", 8'h00, 1'b0, 1'b0, 1'b1);

        foreach (seq0[i]) begin
            step("en_on",  seq0[i], 1'b0, 1'b1);
            step("en_off", 8'hA5,   1'b0, 1'b0);
        end

        for (int i = 0; i < 6; i++) step("pre_rst", seq0[i]);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step("post_rst", seq0[i]);

        step("cap_clr", 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("cap_first", t3[i]);
        step("cap_b", 8'h07);
        step("cap_c", 8'h0F);
        step("cap_second", 8'h3F);
        step("cap_clear", 8'h00, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
